// File: rtl/mod_quarterer_pkg.sv
// Shared definitions for the modular quarterer datapath.
// Holds the default operand/modulus width used across the block.
package mod_quarterer_pkg;

    localparam int BITWIDTH_DEFAULT = 8;

endpackage

// File: rtl/mod_quarterer_if.sv
// Valid/ready handshake bundle for mod_quarterer: upstream operand/modulus
// plus downstream result, with master (driver) and slave (block) views.
interface mod_quarterer_if
    import mod_quarterer_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEFAULT
);
    logic                iValid;
    logic                oReady;
    logic [BITWIDTH-1:0] iData;
    logic [BITWIDTH-1:0] iQ;
    logic                oValid;
    logic                iReady;
    logic [BITWIDTH-1:0] oData;

    modport master (
        output iValid, iData, iQ, iReady,
        input  oReady, oValid, oData
    );

    modport slave (
        input  iValid, iData, iQ, iReady,
        output oReady, oValid, oData
    );
endinterface

// File: rtl/mod_halver.sv
// Combinational modular divide-by-2: y = x * 2^-1 mod q for odd q.
// Odd x gets q added first so the sum is even; the carry bit keeps q near 2^BITWIDTH exact.
module mod_halver
    import mod_quarterer_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEFAULT
) (
    input  logic [BITWIDTH-1:0] x,
    input  logic [BITWIDTH-1:0] q,
    output logic [BITWIDTH-1:0] y
);
    logic [BITWIDTH:0] sum;

    assign sum = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
    assign y   = sum[BITWIDTH:1];
endmodule

// File: rtl/mod_quarterer.sv
// Modular quarterer: oData = iData * 4^-1 mod iQ, built from two pipelined
// halving stages with valid/ready flow control on both sides.
module mod_quarterer
    import mod_quarterer_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEFAULT
) (
    input  logic            iClk,
    input  logic            iRst,
    mod_quarterer_if.slave  bus
);
    logic [BITWIDTH-1:0] h_p0;
    logic [BITWIDTH-1:0] h_p1;
    logic [BITWIDTH-1:0] d_p1;
    logic [BITWIDTH-1:0] q_p1;
    logic [BITWIDTH-1:0] d_p2;
    logic                vld_p1;
    logic                vld_p2;
    logic                adv1;
    logic                adv2;
    logic                acc;

    // Stage boundary p0 -> p1: first halving on the incoming operand.
    mod_halver #(.BITWIDTH(BITWIDTH)) u_half_p0 (
        .x (bus.iData),
        .q (bus.iQ),
        .y (h_p0)
    );

    // Stage boundary p1 -> p2: second halving with the modulus carried alongside.
    mod_halver #(.BITWIDTH(BITWIDTH)) u_half_p1 (
        .x (d_p1),
        .q (q_p1),
        .y (h_p1)
    );

    assign adv2       = !vld_p2 || bus.iReady;
    assign adv1       = !vld_p1 || adv2;
    assign acc        = bus.iValid && adv1;
    assign bus.oReady = adv1;
    assign bus.oValid = vld_p2;
    assign bus.oData  = d_p2;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            d_p1   <= '0;
            q_p1   <= '0;
            d_p2   <= '0;
        end else begin
            if (adv1) begin
                vld_p1 <= acc;
                if (acc) begin
                    d_p1 <= h_p0;
                    q_p1 <= bus.iQ;
                end
            end
            // A held result keeps d_p2 untouched; an empty stage 1 only drops the valid.
            if (adv2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    d_p2 <= h_p1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mod_quarterer.sv
// Directed and randomized checks for mod_quarterer: latency, boundary moduli,
// streaming, backpressure, random handshakes and asynchronous reset.
module tb_mod_quarterer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mod_quarterer_if #(.BITWIDTH(8)) bus ();

    mod_quarterer #(.BITWIDTH(8)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iValid = 1'b0;
        bus.iData  = '0;
        bus.iQ     = 8'd17;
        bus.iReady = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #12;
        checks++;
        if (bus.oValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovalid got %b want 0", bus.oValid);
        end
        checks++;
        if (bus.oData !== 8'd0) begin
            errors++;
            $display("FAIL reset_odata got %0d want 0", bus.oData);
        end
        checks++;
        if (bus.oReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_oready got %b want 1", bus.oReady);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int vd[4]  = '{1, 4, 16, 0};
        int vq[4]  = '{17, 17, 17, 17};
        int vex[4] = '{13, 1, 4, 0};
        for (int i = 0; i < 4; i++) begin
            bus.iReady = 1'b1;
            bus.iValid = 1'b1;
            bus.iData  = vd[i][7:0];
            bus.iQ     = vq[i][7:0];
            step();
            bus.iValid = 1'b0;
            checks++;
            if (bus.oValid !== 1'b0) begin
                errors++;
                $display("FAIL basic_early_%0d ovalid got %b want 0", i, bus.oValid);
            end
            step();
            checks++;
            if (bus.oValid !== 1'b1 || bus.oData !== vex[i][7:0]) begin
                errors++;
                $display("FAIL basic_%0d got valid=%b data=%0d want valid=1 data=%0d",
                         i, bus.oValid, bus.oData, vex[i]);
            end
            step();
        end
    endtask

    task automatic test_boundary();
        int vd[2]  = '{254, 250};
        int vq[2]  = '{255, 251};
        int vex[2] = '{191, 188};
        for (int i = 0; i < 2; i++) begin
            bus.iReady = 1'b1;
            bus.iValid = 1'b1;
            bus.iData  = vd[i][7:0];
            bus.iQ     = vq[i][7:0];
            step();
            bus.iValid = 1'b0;
            step();
            checks++;
            if (bus.oValid !== 1'b1 || bus.oData !== vex[i][7:0]) begin
                errors++;
                $display("FAIL boundary_q%0d got valid=%b data=%0d want valid=1 data=%0d",
                         vq[i], bus.oValid, bus.oData, vex[i]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int sd[$];
        int sq[$];
        int nout;
        int d;
        int q;
        int o;
        nout = 0;
        bus.iReady = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (c < 20) begin
                q = 2 * $urandom_range(127, 1) + 1;
                d = $urandom_range(q - 1, 0);
                bus.iValid = 1'b1;
                bus.iData  = d[7:0];
                bus.iQ     = q[7:0];
            end else begin
                bus.iValid = 1'b0;
            end
            #1;
            if (c < 20) begin
                checks++;
                if (bus.oReady !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_oready beat %0d got %b want 1", c, bus.oReady);
                end
            end
            if (c >= 2) begin
                checks++;
                if (bus.oValid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_gap cycle %0d ovalid got %b want 1", c, bus.oValid);
                end
            end
            if (bus.oValid === 1'b1 && sd.size() > 0) begin
                o = int'(bus.oData);
                nout++;
                checks++;
                if (o >= sq[0] || ((4 * o) % sq[0]) != sd[0]) begin
                    errors++;
                    $display("FAIL stream_value got %0d want 4*y mod %0d == %0d", o, sq[0], sd[0]);
                end
                void'(sd.pop_front());
                void'(sq.pop_front());
            end
            if (bus.iValid === 1'b1 && bus.oReady === 1'b1) begin
                sd.push_back(d);
                sq.push_back(q);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (nout != 20) begin
            errors++;
            $display("FAIL stream_count got %0d want 20", nout);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_backpressure();
        bus.iReady = 1'b0;
        bus.iQ     = 8'd17;
        bus.iValid = 1'b1;
        bus.iData  = 8'd1;
        step();
        bus.iData  = 8'd4;
        step();
        bus.iData  = 8'd16;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.oReady !== 1'b0 || bus.oValid !== 1'b1 || bus.oData !== 8'd13) begin
                errors++;
                $display("FAIL bp_hold_%0d got ready=%b valid=%b data=%0d want ready=0 valid=1 data=13",
                         k, bus.oReady, bus.oValid, bus.oData);
            end
            step();
        end
        bus.iReady = 1'b1;
        #1;
        checks++;
        if (bus.oReady !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_oready got %b want 1", bus.oReady);
        end
        step();
        bus.iValid = 1'b0;
        checks++;
        if (bus.oValid !== 1'b1 || bus.oData !== 8'd1) begin
            errors++;
            $display("FAIL bp_drain_second got valid=%b data=%0d want valid=1 data=1",
                     bus.oValid, bus.oData);
        end
        step();
        checks++;
        if (bus.oValid !== 1'b1 || bus.oData !== 8'd4) begin
            errors++;
            $display("FAIL bp_third got valid=%b data=%0d want valid=1 data=4",
                     bus.oValid, bus.oData);
        end
        step();
        checks++;
        if (bus.oValid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty ovalid got %b want 0", bus.oValid);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int sd[$];
        int sq[$];
        int d;
        int q;
        int o;
        logic        held;
        logic [7:0]  held_data;
        held      = 1'b0;
        held_data = '0;
        d = 0;
        q = 3;
        for (int c = 0; c < 1010; c++) begin
            if (c < 1000) begin
                if (!(bus.iValid === 1'b1 && bus.oReady === 1'b0) || c == 0) begin
                    q = 2 * $urandom_range(127, 1) + 1;
                    d = $urandom_range(q - 1, 0);
                end
                bus.iValid = ($urandom_range(3, 0) != 0);
                bus.iData  = d[7:0];
                bus.iQ     = q[7:0];
                bus.iReady = ($urandom_range(2, 0) != 0);
            end else begin
                bus.iValid = 1'b0;
                bus.iReady = 1'b1;
            end
            #1;
            if (held) begin
                checks++;
                if (bus.oValid !== 1'b1 || bus.oData !== held_data) begin
                    errors++;
                    $display("FAIL rand_stable cycle %0d got valid=%b data=%0d want valid=1 data=%0d",
                             c, bus.oValid, bus.oData, held_data);
                end
            end
            if (bus.oValid === 1'b1 && bus.iReady === 1'b1) begin
                o = int'(bus.oData);
                checks++;
                if (sd.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra cycle %0d got data=%0d want no output", c, o);
                end else begin
                    if (o >= sq[0] || ((4 * o) % sq[0]) != sd[0]) begin
                        errors++;
                        $display("FAIL rand_value cycle %0d got %0d want 4*y mod %0d == %0d",
                                 c, o, sq[0], sd[0]);
                    end
                    void'(sd.pop_front());
                    void'(sq.pop_front());
                end
            end
            if (bus.iValid === 1'b1 && bus.oReady === 1'b1) begin
                sd.push_back(d);
                sq.push_back(q);
            end
            held      = (bus.oValid === 1'b1) && (bus.iReady === 1'b0);
            held_data = bus.oData;
            @(posedge clk);
            #1;
        end
        checks++;
        if (sd.size() != 0) begin
            errors++;
            $display("FAIL rand_drain outstanding got %0d want 0", sd.size());
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        bus.iReady = 1'b0;
        bus.iValid = 1'b1;
        bus.iQ     = 8'd17;
        bus.iData  = 8'd1;
        step();
        bus.iData  = 8'd4;
        step();
        bus.iValid = 1'b0;
        #1;
        checks++;
        if (bus.oValid !== 1'b1 || bus.oReady !== 1'b0) begin
            errors++;
            $display("FAIL areset_full got valid=%b ready=%b want valid=1 ready=0",
                     bus.oValid, bus.oReady);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.oValid !== 1'b0 || bus.oData !== 8'd0) begin
            errors++;
            $display("FAIL areset_immediate got valid=%b data=%0d want valid=0 data=0",
                     bus.oValid, bus.oData);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        bus.iReady = 1'b1;
        step();
        checks++;
        if (bus.oValid !== 1'b0) begin
            errors++;
            $display("FAIL areset_flushed ovalid got %b want 0", bus.oValid);
        end
        bus.iValid = 1'b1;
        bus.iData  = 8'd1;
        bus.iQ     = 8'd17;
        step();
        bus.iValid = 1'b0;
        step();
        checks++;
        if (bus.oValid !== 1'b1 || bus.oData !== 8'd13) begin
            errors++;
            $display("FAIL areset_fresh got valid=%b data=%0d want valid=1 data=13",
                     bus.oValid, bus.oData);
        end
        step();
        checks++;
        if (bus.oValid !== 1'b0) begin
            errors++;
            $display("FAIL areset_single ovalid got %b want 0", bus.oValid);
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
